// File: rtl/core_pkg.sv
// Shared definitions for the decode/issue slice of the core.
//   REG_AW / NREGS : architectural register address width and count
//   OP_W           : opcode field width
//   OP_*           : RV32 major opcodes carried through the issue stage
//   instr_t        : decoded instruction fields as held by the issue register
//   reg_onehot     : register address to one-hot register mask
package core_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned OP_W   = 7;

    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_OP     = 7'b0110011;
    localparam logic [OP_W-1:0] OP_OPIMM  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rw;
        logic              write;
        logic [OP_W-1:0]   operation;
    } instr_t;

    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
        logic [NREGS-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register scoreboard for the in-order issue controller.
// Tracks which registers have an in-flight producer and how many writes are outstanding.
//   clk, rst_n                    : clock, async active-low reset
//   set_valid/set_rw              : new producer accepted for set_rw
//   clr_valid/clr_rw              : writeback of clr_rw (ignored unless the register is busy)
//   flush_clr_valid/flush_clr_rw  : producer dropped by a flush before reaching execute
//   rs1, rs2, rw, write           : lookup of the instruction offered by the decoder
//   hazard                        : RAW/WAW conflict against busy (after same-cycle writeback)
//   count_full                    : no room for another register write this cycle
//   busy                          : scoreboard vector, bit 0 always 0
module issue_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_valid,
    input  logic [REG_AW-1:0] set_rw,
    input  logic              clr_valid,
    input  logic [REG_AW-1:0] clr_rw,
    input  logic              flush_clr_valid,
    input  logic [REG_AW-1:0] flush_clr_rw,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rw,
    input  logic              write,
    output logic              hazard,
    output logic              count_full,
    output logic [NREGS-1:0]  busy
);

    localparam logic [CNT_W:0] MaxCnt = (CNT_W+1)'(MAX_OUTSTANDING);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] wb_mask, busy_eff;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W:0]   cnt_avail, cnt_next;
    logic             wb_dec, flush_dec, set_inc;

    always_comb begin
        wb_mask  = clr_valid ? reg_onehot(clr_rw) : '0;
        busy_eff = busy_q & ~wb_mask;

        wb_dec  = clr_valid & busy_q[clr_rw];
        // A writeback and a flush naming the same register retire one producer, not two.
        flush_dec = flush_clr_valid & (flush_clr_rw != '0) & busy_q[flush_clr_rw]
                  & ~(wb_dec & (clr_rw == flush_clr_rw));
        set_inc = set_valid & (set_rw != '0);

        hazard = busy_eff[rs1] | busy_eff[rs2] | (write & busy_eff[rw]);

        cnt_avail  = {1'b0, count_q} - {{CNT_W{1'b0}}, wb_dec};
        count_full = (cnt_avail >= MaxCnt);

        // Set is applied last so a new producer owns a register released this cycle.
        busy_d = busy_q;
        if (wb_dec)    busy_d[clr_rw]       = 1'b0;
        if (flush_dec) busy_d[flush_clr_rw] = 1'b0;
        if (set_inc)   busy_d[set_rw]       = 1'b1;
        busy_d[0] = 1'b0;

        cnt_next = {1'b0, count_q};
        if (set_inc)                          cnt_next = cnt_next + 1'b1;
        if (wb_dec && (cnt_next != '0))       cnt_next = cnt_next - 1'b1;
        if (flush_dec && (cnt_next != '0))    cnt_next = cnt_next - 1'b1;
        if (cnt_next > MaxCnt)                cnt_next = MaxCnt;
        count_d = cnt_next[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/issue_ctrl.sv
// In-order single-issue controller between decode and execute.
// Accepts decoded fields over dec_valid/dec_ready, holds back RAW/WAW hazards via
// issue_scoreboard and presents issued instructions from a one-entry output register.
//   clk, rst_n            : clock, async active-low reset
//   dec_*                 : decoder handshake and fields (dec_ready is combinational)
//   iss_*                 : output register towards execute
//   wb_valid, wb_rw       : writeback releases a scoreboard entry
//   flush                 : drop the held instruction, block acceptance this cycle
//   busy                  : scoreboard vector
// Optional (ISSUE_PERF_EN defined): perf_clr input, stall_cycles output counting
// cycles with dec_valid=1 and dec_ready=0, saturating.
module issue_ctrl
    import core_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic [REG_AW-1:0] dec_rw,
    input  logic              dec_write,
    input  logic [OP_W-1:0]   dec_operation,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [REG_AW-1:0] iss_rs1,
    output logic [REG_AW-1:0] iss_rs2,
    output logic [REG_AW-1:0] iss_rw,
    output logic              iss_write,
    output logic [OP_W-1:0]   iss_operation,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rw,
    input  logic              flush,
    output logic [NREGS-1:0]  busy
`ifdef ISSUE_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [31:0]       stall_cycles
`endif
);

    instr_t iss_q, iss_d;
    logic   iss_valid_q, iss_valid_d;
    logic   hazard, count_full, transfer;
    logic   flush_clr_valid;

    // Only a held write that execute has not taken is dropped from the scoreboard.
    assign flush_clr_valid = flush & iss_valid_q & ~iss_ready & iss_q.write;

    issue_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_scoreboard (
        .clk             (clk),
        .rst_n           (rst_n),
        .set_valid       (transfer & dec_write),
        .set_rw          (dec_rw),
        .clr_valid       (wb_valid),
        .clr_rw          (wb_rw),
        .flush_clr_valid (flush_clr_valid),
        .flush_clr_rw    (iss_q.rw),
        .rs1             (dec_rs1),
        .rs2             (dec_rs2),
        .rw              (dec_rw),
        .write           (dec_write),
        .hazard          (hazard),
        .count_full      (count_full),
        .busy            (busy)
    );

    always_comb begin
        dec_ready = rst_n & (~iss_valid_q | iss_ready) & ~hazard
                  & ~(dec_write & count_full) & ~flush;
        transfer  = dec_valid & dec_ready;

        iss_d       = iss_q;
        iss_valid_d = iss_valid_q;
        if (transfer) begin
            iss_d.rs1       = dec_rs1;
            iss_d.rs2       = dec_rs2;
            iss_d.rw        = dec_rw;
            iss_d.write     = dec_write;
            iss_d.operation = dec_operation;
            iss_valid_d     = 1'b1;
        end else if (flush || iss_ready) begin
            iss_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q       <= '0;
            iss_valid_q <= 1'b0;
        end else begin
            iss_q       <= iss_d;
            iss_valid_q <= iss_valid_d;
        end
    end

    assign iss_valid     = iss_valid_q;
    assign iss_rs1       = iss_q.rs1;
    assign iss_rs2       = iss_q.rs2;
    assign iss_rw        = iss_q.rw;
    assign iss_write     = iss_q.write;
    assign iss_operation = iss_q.operation;

`ifdef ISSUE_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (perf_clr) begin
            stall_d = '0;
        end else if (dec_valid && !dec_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
In-order single-issue controller between the instruction decoder and the execute stage. Accepts decoded fields (rs1, rs2, rw, write, operation) over a valid/ready handshake. A 32-entry register scoreboard holds back RAW/WAW hazards, and a one-entry output register presents issued instructions to execute. Writeback releases scoreboard entries.

Parameters:
MAX_OUTSTANDING, 4, maximum in-flight register writes (issued, not yet written back); range 1..31
CNT_W, 3, outstanding-counter width; must satisfy 2**CNT_W > MAX_OUTSTANDING

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  decoder presents an instruction
dec_ready  out  1  controller accepts this cycle
dec_rs1  in  5  source register 1
dec_rs2  in  5  source register 2
dec_rw  in  5  destination register
dec_write  in  1  instruction writes rw
dec_operation  in  7  opcode field
iss_valid  out  1  output register holds an instruction
iss_ready  in  1  execute consumes it
iss_rs1, iss_rs2, iss_rw  out  5 each  registered copies
iss_write  out  1  registered copy
iss_operation  out  7  registered copy
wb_valid  in  1  writeback completes
wb_rw  in  5  register written back
flush  in  1  drop the held instruction and block acceptance
busy  out  32  scoreboard vector; bit 0 is always 0

Behaviour:
- Reset (async, rst_n=0): iss_valid=0; all iss_* fields=0; busy=0; outstanding count=0. dec_ready is combinational and is 0 while rst_n=0.
- Effective busy: busy_eff = busy & ~(wb_valid ? onehot(wb_rw) : 0). A writeback in the same cycle releases its register to the hazard check.
- Hazard = busy_eff[dec_rs1] | busy_eff[dec_rs2] | (dec_write & busy_eff[dec_rw]). Register 0 never hazards.
- Accept condition: dec_ready = (!iss_valid | iss_ready) & !hazard & (dec_write ? count_next_free : 1) & !flush.
  - count_next_free = (count - wb_dec) < MAX_OUTSTANDING.
  - wb_dec = 1 when wb_valid and busy[wb_rw] are both set.
- Transfer (dec_valid & dec_ready): on the next edge, fields load into iss_*, and iss_valid=1.
  - If dec_write and dec_rw != 0: busy[dec_rw] is set and count is incremented.
  - Accepted instructions with rw=0 or write=0 never touch busy or count.
  - Latency: exactly 1 cycle from decode transfer to iss_valid.
- Hold: iss_valid=1 and iss_ready=0 keeps iss_* stable. iss_valid=1 and iss_ready=1 with no new transfer clears iss_valid next cycle. Back-to-back transfers sustain one instruction per cycle.
- Writeback: wb_valid with busy[wb_rw]=1 clears the bit and decrements count. wb_valid on a non-busy register, or on x0, is ignored.
- Simultaneous set and clear of the same register: set wins (the new producer owns it). Count nets to unchanged.
- Flush:
  - Next edge: iss_valid=0.
  - If the dropped entry had write=1 and rw!=0: its busy bit is cleared and count is decremented.
  - If iss_ready was also high that cycle, the entry counts as consumed and its bit stays set.
  - Other busy bits are unaffected; writebacks still retire them.
- Count never underflows or exceeds MAX_OUTSTANDING.

Optional Feature:
ISSUE_PERF_EN defined:
- Adds output stall_cycles (32 bit) and input perf_clr (1 bit).
- stall_cycles increments each cycle where dec_valid=1 and dec_ready=0. It saturates at all ones.
- Async reset sets it to 0. perf_clr=1 sets it to 0 on the next edge.

Without ISSUE_PERF_EN: no port, no counter logic.

Decomposition:
- Shared package core_pkg holds:
  - REG_AW=5, NREGS=32, OP_W=7
  - RV opcode localparams (OP_LUI, OP_OP, OP_OPIMM, OP_LOAD, OP_STORE, OP_BRANCH)
- One sub-module, issue_scoreboard, owns the busy vector, outstanding counter and hazard logic.
  - Inputs: set port, clear port, flush-clear port, three lookup addresses.
  - Outputs: hazard, count_full.
- issue_ctrl keeps the handshake and output register.

Test Plan:
- Reset mid-stream: iss_valid=1, busy[5]=1, then rst_n=0 -> immediately iss_valid=0, busy=0; after release, dec_ready=1 for a clean instruction.
- RAW stall: issue rw=5 write=1, then rs1=5, rs2=2 -> dec_ready=0 until wb_valid with wb_rw=5; the dependent instruction is accepted that same wb cycle and iss_valid rises next cycle.
- x0 handling: rw=0 write=1 -> busy stays 0, count stays 0; a following rs1=0 instruction issues without stall.
- Outstanding limit (MAX_OUTSTANDING=4): writes to x1..x4 accepted, write to x6 -> dec_ready=0; wb_rw=1 -> accepted in the same cycle.
- Backpressure: iss_ready=0 for 3 cycles with dec_valid=1 -> iss_* stable and dec_ready=0; iss_ready=1 -> one transfer per cycle resumes.
- Flush of held write rw=7 with iss_ready=0 -> iss_valid=0 and busy[7]=0 next cycle, count decremented; with ISSUE_PERF_EN defined, stall_cycles equals the number of stalled valid cycles.
